// File: rtl/spi_counter_rx.sv
// SPI mode-0 slave: receives 16-bit MSB-first frames and holds the last in-range value as the
// FND counter, shifting the held value back out on miso during the next frame.
module spi_counter_rx #(
    parameter int FRAME_W     = 16,
    parameter int CNT_W       = 14,
    parameter int MAX_VALUE   = 9999,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ss_n,
    output logic             miso,
    output logic [CNT_W-1:0] counter,
    output logic             rx_done,
    output logic             frame_err
);

    localparam int BC_W = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, WAIT_SS} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_n_sync_q, flush_q;
    logic                   sclk_prev_q, ss_n_prev_q, armed_q;

    state_e                 state_q;
    logic [BC_W-1:0]        bit_cnt_q;
    logic [FRAME_W-1:0]     rx_q, tx_q;
    logic [CNT_W-1:0]       counter_q;
    logic                   miso_q, rx_done_q, frame_err_q;

    logic sclk_s, mosi_s, ss_n_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [FRAME_W-1:0] tx_load;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_n_s    = ss_n_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_n_s & ~ss_n_prev_q;
    // A frame may only start once ss_n has been seen high through a flushed synchronizer,
    // so ss_n held low across reset release never looks like a fresh select edge.
    assign ss_fall   = armed_q & ss_n_prev_q & ~ss_n_s;
    assign tx_load   = {{(FRAME_W-CNT_W){1'b0}}, counter_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_n_sync_q <= '1;
            flush_q     <= '0;
            sclk_prev_q <= 1'b0;
            ss_n_prev_q <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ss_n_sync_q <= {ss_n_sync_q[SYNC_STAGES-2:0], ss_n};
            flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            ss_n_prev_q <= ss_n_s;
            armed_q     <= armed_q | (flush_q[SYNC_STAGES-1] & ss_n_s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            counter_q   <= '0;
            miso_q      <= 1'b0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle; only the branches below raise them for one clk.
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (ss_fall) begin
                        bit_cnt_q <= '0;
                        tx_q      <= tx_load;
                        miso_q    <= tx_load[FRAME_W-1];
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The last rise wins over a simultaneous deselect: the frame is complete.
                    if (sclk_rise && bit_cnt_q == BC_W'(FRAME_W - 1)) begin
                        rx_q      <= {rx_q[FRAME_W-2:0], mosi_s};
                        bit_cnt_q <= BC_W'(FRAME_W);
                        state_q   <= CHECK;
                    end else if (ss_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        if (sclk_rise) begin
                            rx_q      <= {rx_q[FRAME_W-2:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                        if (sclk_fall && bit_cnt_q != '0) begin
                            tx_q   <= {tx_q[FRAME_W-2:0], 1'b0};
                            miso_q <= tx_q[FRAME_W-2];
                        end
                    end
                end
                CHECK: begin
                    if (rx_q[FRAME_W-1:CNT_W] == '0 &&
                        rx_q[CNT_W-1:0] <= CNT_W'(MAX_VALUE)) begin
                        counter_q <= rx_q[CNT_W-1:0];
                        rx_done_q <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    state_q <= ss_n_s ? IDLE : WAIT_SS;
                end
                WAIT_SS: begin
                    if (ss_rise) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso      = miso_q;
    assign counter   = counter_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

endmodule
